// File: rtl/xillybus_seek_regbank.sv
// +-----------------------------------------------------------------------------+
// | xillybus_seek_regbank                                                       |
// | Seekable register-array responder for one Xillybus stream pair.             |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module xillybus_seek_regbank #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter bit WRAP   = 1'b0
) (
   input  logic              bus_clk,
   input  logic              bus_reset_n,
   input  logic              user_r_open,
   input  logic              user_r_rden,
   output logic [DATA_W-1:0] user_r_data,
   output logic              user_r_empty,
   output logic              user_r_eof,
   input  logic              user_w_open,
   input  logic              user_w_wren,
   input  logic [DATA_W-1:0] user_w_data,
   output logic              user_w_full,
   input  logic [ADDR_W-1:0] user_addr,
   input  logic              user_addr_update,
   input  logic              hw_we,
   input  logic [ADDR_W-1:0] hw_waddr,
   input  logic [DATA_W-1:0] hw_wdata,
   input  logic [ADDR_W-1:0] hw_raddr,
   output logic [DATA_W-1:0] hw_rdata,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_ptr;
   logic              r_open_q;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_hw_rdata;
   logic              r_wr_strobe;
   logic [ADDR_W-1:0] r_wr_addr;

   logic              w_end;
   logic              w_rd_ok;
   logic              w_wr_ok;
   logic              w_open;
   logic              w_open_rise;
   logic [ADDR_W:0]   w_ptr_inc;
   logic [ADDR_W:0]   w_ptr_nxt;

   // Bit ADDR_W of the pointer can only become set in non-wrapping mode.
   assign w_end       = r_ptr[ADDR_W];
   assign w_rd_ok     = user_r_rden & ~w_end;
   assign w_wr_ok     = user_w_wren & ~w_end;
   assign w_open      = user_r_open | user_w_open;
   assign w_open_rise = w_open & ~r_open_q;

   generate
      if (WRAP) begin : g_wrap
         assign w_ptr_inc    = {1'b0, r_ptr[ADDR_W-1:0] + ADDR_W'(1)};
         assign user_r_empty = 1'b0;
         assign user_r_eof   = 1'b0;
         assign user_w_full  = 1'b0;
      end else begin : g_nowrap
         assign w_ptr_inc    = r_ptr + (ADDR_W+1)'(1);
         assign user_r_empty = w_end;
         assign user_r_eof   = w_end;
         assign user_w_full  = w_end;
      end
   endgenerate

   // Seek beats the open-edge rewind, and both beat the access increment.
   always_comb begin
      w_ptr_nxt = r_ptr;
      if (user_addr_update)
         w_ptr_nxt = {1'b0, user_addr};
      else if (w_open_rise)
         w_ptr_nxt = '0;
      else if (w_rd_ok | w_wr_ok)
         w_ptr_nxt = w_ptr_inc;
   end

   always_ff @(posedge bus_clk or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
         r_ptr       <= '0;
         r_open_q    <= 1'b0;
         r_rdata     <= '0;
         r_hw_rdata  <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         r_ptr       <= w_ptr_nxt;
         r_open_q    <= w_open;
         r_hw_rdata  <= r_mem[hw_raddr];
         r_wr_strobe <= w_wr_ok;
         if (w_rd_ok)
            r_rdata <= r_mem[r_ptr[ADDR_W-1:0]];
         if (w_wr_ok)
            r_wr_addr <= r_ptr[ADDR_W-1:0];
         // The host write is issued last so it wins an address collision.
         if (hw_we)
            r_mem[hw_waddr] <= hw_wdata;
         if (w_wr_ok)
            r_mem[r_ptr[ADDR_W-1:0]] <= user_w_data;
      end
   end

   assign user_r_data = r_rdata;
   assign hw_rdata    = r_hw_rdata;
   assign wr_strobe   = r_wr_strobe;
   assign wr_addr     = r_wr_addr;

endmodule

`default_nettype wire

// File: tb/tb_xillybus_seek_regbank.sv
// +-----------------------------------------------------------------------------+
// | tb_xillybus_seek_regbank                                                    |
// | Directed bench: non-wrapping instance u0 and wrapping instance u1.          |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_xillybus_seek_regbank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r_open, w_open, rden, wren, addr_upd, hw_we, en1;
   logic [15:0] w_data, hw_wdata;
   logic [4:0]  addr, hw_waddr, hw_raddr;

   logic [15:0] r_data0, hw_rdata0, r_data1, hw_rdata1;
   logic        empty0, eof0, full0, strb0, empty1, eof1, full1, strb1;
   logic [4:0]  wa0, wa1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xillybus_seek_regbank #(.DATA_W(16), .ADDR_W(5), .WRAP(1'b0)) u0 (
      .bus_clk(clk), .bus_reset_n(rst_n),
      .user_r_open(r_open), .user_r_rden(rden), .user_r_data(r_data0),
      .user_r_empty(empty0), .user_r_eof(eof0),
      .user_w_open(w_open), .user_w_wren(wren), .user_w_data(w_data),
      .user_w_full(full0), .user_addr(addr), .user_addr_update(addr_upd),
      .hw_we(hw_we), .hw_waddr(hw_waddr), .hw_wdata(hw_wdata),
      .hw_raddr(hw_raddr), .hw_rdata(hw_rdata0),
      .wr_strobe(strb0), .wr_addr(wa0)
   );

   xillybus_seek_regbank #(.DATA_W(16), .ADDR_W(5), .WRAP(1'b1)) u1 (
      .bus_clk(clk), .bus_reset_n(rst_n),
      .user_r_open(r_open), .user_r_rden(rden & en1), .user_r_data(r_data1),
      .user_r_empty(empty1), .user_r_eof(eof1),
      .user_w_open(w_open), .user_w_wren(wren & en1), .user_w_data(w_data),
      .user_w_full(full1), .user_addr(addr), .user_addr_update(addr_upd),
      .hw_we(hw_we), .hw_waddr(hw_waddr), .hw_wdata(hw_wdata),
      .hw_raddr(hw_raddr), .hw_rdata(hw_rdata1),
      .wr_strobe(strb1), .wr_addr(wa1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic seek(input logic [4:0] a);
      addr     = a;
      addr_upd = 1'b1;
      step();
      addr_upd = 1'b0;
   endtask

   task automatic peek(input logic [4:0] a, input logic [15:0] exp, input string tag);
      hw_raddr = a;
      step();
      chk(tag, hw_rdata0, exp);
   endtask

   initial begin
      rst_n = 1'b0; r_open = 0; w_open = 0; rden = 0; wren = 0; addr_upd = 0;
      hw_we = 0; en1 = 1; w_data = '0; hw_wdata = '0; addr = '0;
      hw_waddr = '0; hw_raddr = '0;
      step(); step();
      chk("rst_rdata", r_data0, 16'h0);
      chk("rst_flags", {empty0, eof0, full0, strb0}, 4'b0000);
      chk("rst_hw_rdata", hw_rdata0, 16'h0);
      rst_n = 1'b1;
      step();

      // three writes, then asynchronous reset mid-stream
      w_open = 1'b1;
      step();
      wren = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_data = 16'h000A + 16'(i);
         step();
      end
      wren = 1'b0;
      chk("pre_rst_strobe", {strb0, wa0}, {1'b1, 5'd2});
      chk("pre_rst_hw_rdata", hw_rdata0, 16'h000A);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_strobe", {strb0, wa0}, 6'd0);
      chk("async_rst_hw_rdata", hw_rdata0, 16'h0);
      step();
      rst_n = 1'b1;
      peek(5'd0, 16'h0, "rst_mem0_cleared");
      peek(5'd2, 16'h0, "rst_mem2_cleared");

      // 32 back-to-back writes from pointer 0
      wren = 1'b1;
      for (int i = 0; i < 32; i++) begin
         w_data = 16'h1000 + 16'(i);
         step();
         chk($sformatf("wr%0d_strobe", i), {strb0, wa0}, {1'b1, 5'(i)});
         chk($sformatf("wr%0d_full", i), full0, (i == 31) ? 1'b1 : 1'b0);
      end
      chk("wrap_full_low", {full1, strb1, wa1}, {1'b0, 1'b1, 5'd31});
      en1 = 1'b0;
      w_data = 16'hDEAD;
      step();
      wren = 1'b0;
      en1 = 1'b1;
      chk("wr33_no_strobe", strb0, 1'b0);
      chk("wr33_full_held", full0, 1'b1);
      peek(5'd0, 16'h1000, "wr33_mem0_kept");

      // reads at end of array
      seek(5'd30);
      chk("seek30_empty", {empty0, eof0, full0}, 3'b000);
      rden = 1'b1;
      step();
      chk("rd30_data", r_data0, 16'h101E);
      chk("rd30_empty", empty0, 1'b0);
      step();
      rden = 1'b0;
      chk("rd31_data", r_data0, 16'h101F);
      chk("rd31_flags", {empty0, eof0, full0}, 3'b111);
      en1 = 1'b0;
      rden = 1'b1;
      step();
      rden = 1'b0;
      en1 = 1'b1;
      chk("rd_empty_ignored", {r_data0, empty0}, {16'h101F, 1'b1});
      seek(5'd5);
      chk("seek5_flags", {empty0, eof0}, 2'b00);
      rden = 1'b1;
      step();
      rden = 1'b0;
      chk("rd5_data", r_data0, 16'h1005);

      // wrapping instance
      seek(5'd31);
      rden = 1'b1;
      step();
      chk("wrap_rd31", r_data1, 16'h101F);
      step();
      rden = 1'b0;
      chk("wrap_rd0", r_data1, 16'h1000);
      chk("wrap_flags", {empty1, eof1, full1}, 3'b000);

      // host/fabric write collisions
      seek(5'd7);
      wren = 1'b1; w_data = 16'hAAAA;
      hw_we = 1'b1; hw_waddr = 5'd7; hw_wdata = 16'h5555;
      step();
      wren = 1'b0; hw_we = 1'b0;
      peek(5'd7, 16'hAAAA, "coll_same_host_wins");
      seek(5'd7);
      wren = 1'b1; hw_we = 1'b1; hw_waddr = 5'd8;
      step();
      wren = 1'b0; hw_we = 1'b0;
      peek(5'd7, 16'hAAAA, "coll_diff_host");
      peek(5'd8, 16'h5555, "coll_diff_fabric");

      // seek coincident with write
      seek(5'd4);
      wren = 1'b1; w_data = 16'h4444; addr = 5'd12; addr_upd = 1'b1;
      step();
      addr_upd = 1'b0;
      chk("seekwr_addr4", wa0, 5'd4);
      w_data = 16'h1212;
      step();
      wren = 1'b0;
      chk("seekwr_addr12", wa0, 5'd12);
      peek(5'd4, 16'h4444, "seekwr_mem4");
      peek(5'd12, 16'h1212, "seekwr_mem12");
      peek(5'd13, 16'h100D, "seekwr_mem13");

      // open rising edge rewinds pointer; read vs fabric write at same address
      w_open = 1'b0; r_open = 1'b0;
      step(); step();
      r_open = 1'b1;
      step();
      rden = 1'b1; hw_we = 1'b1; hw_waddr = 5'd0; hw_wdata = 16'h7777;
      step();
      hw_we = 1'b0;
      chk("open_rd0_old", r_data0, 16'h1000);
      step();
      rden = 1'b0;
      chk("open_rd1", r_data0, 16'h1001);
      peek(5'd0, 16'h7777, "fabric_wr0");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/xillybus_seek_regbank.md
# xillybus_seek_regbank

User-side responder for one Xillybus seekable stream pair: the endpoint that answers the core's `rden`/`wren`/`addr_update` requests for a 16-bit address-seekable device such as the control- or status-register streams. It holds a register array of 2^ADDR_W words, services host reads and writes through a shared auto-incrementing pointer, and reports end-of-array through `empty`, `eof` and `full`. It also gives on-chip logic a second write/read port and a per-write strobe.

## Interface
- DATA_W, 16, word width of the array and both stream data buses
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W words
- WRAP, 0, 1 = pointer wraps DEPTH-1 -> 0 and streams never end; 0 = stream ends at DEPTH

Ports:
- bus_clk  in  1  sole clock, rising edge
- bus_reset_n  in  1  asynchronous, active-low reset
- user_r_open  in  1  host read file open
- user_r_rden  in  1  host read request
- user_r_data  out  DATA_W  read word, valid the cycle after `rden`
- user_r_empty  out  1  no word available; core must not assert `rden`
- user_r_eof  out  1  end of file on read stream
- user_w_open  in  1  host write file open
- user_w_wren  in  1  host write request, data same cycle
- user_w_data  in  DATA_W  host write word
- user_w_full  out  1  no space; core must not assert `wren`
- user_addr  in  ADDR_W  seek address
- user_addr_update  in  1  seek strobe
- hw_we  in  1  fabric write enable
- hw_waddr  in  ADDR_W  fabric write address
- hw_wdata  in  DATA_W  fabric write data
- hw_raddr  in  ADDR_W  fabric read address
- hw_rdata  out  DATA_W  fabric read data, registered
- wr_strobe  out  1  one-cycle pulse per accepted host write
- wr_addr  out  ADDR_W  address of the host write flagged by `wr_strobe`

## Operation
- Pointer `ptr` is ADDR_W+1 bits; bit ADDR_W set means past end (non-WRAP mode only).
- Host read: `rden` with `ptr < DEPTH` -> `user_r_data <= mem[ptr]`, `ptr <= ptr+1`. A `rden` while `empty` is a protocol violation; ignore it with no pointer or data change.
- Host write: `wren` with `ptr < DEPTH` -> `mem[ptr] <= user_w_data`, `ptr <= ptr+1`, `wr_strobe <= 1`, `wr_addr <= ptr`. A `wren` while `full` is ignored.
- WRAP=1: increment from DEPTH-1 gives 0; `empty`, `eof` and `full` are held at 0.
- WRAP=0: `empty = eof = full = ptr[ADDR_W]`.
- Seek: `addr_update` -> `ptr <= {0, user_addr}`. If `rden` or `wren` fires in the same cycle, the access uses the old `ptr` and the seek value overrides the increment.
- Open edge: when `r_open|w_open` rises from both-low, `ptr <= 0`. `addr_update` in the same cycle takes priority.
- Fabric write: `hw_we` -> `mem[hw_waddr] <= hw_wdata`. If a host write targets the same address in the same cycle, the host write wins. Different addresses both commit.
- Fabric read: `hw_rdata <= mem[hw_raddr]` every cycle.
- Host `rden` and fabric write to the same address in the same cycle: `user_r_data` returns the old word.

## Timing
- Reset (async assert, sync release): `ptr=0`, all mem words 0, `user_r_data=0`, `hw_rdata=0`, `wr_strobe=0`, `wr_addr=0`, `empty=eof=full=0`.
- Read latency: `rden` in cycle N -> data on `user_r_data` from cycle N+1, held until the next accepted `rden`.
- Write latency: `wren` in cycle N -> word readable by the fabric port at `hw_raddr` in cycle N+1, visible on `hw_rdata` in N+2; `wr_strobe` high in N+1 only.
- Flags are registered from `ptr`. After an access at DEPTH-1 in cycle N, `empty`/`full` go high in N+1. Back-to-back `rden`/`wren` every cycle is supported.
- Seek in cycle N: flags reflect the new `ptr` from N+1. Seeking to any address clears `eof`.

## Test plan
- Reset mid-stream (after 3 writes, `ptr=3`): deassert `bus_reset_n` asynchronously -> all outputs 0 immediately, `ptr=0`, mem cleared.
- WRAP=0: seek to 0, write 32 words 0x1000..0x101F back-to-back -> `wr_strobe` 32 pulses with `wr_addr` 0..31; `full` high the cycle after the 32nd write; a 33rd `wren` changes nothing.
- Read sequence:
  - seek to 30, `rden` x2 -> `user_r_data` = 0x101E then 0x101F, one cycle after each `rden`;
  - `empty=eof=1` the cycle after the second `rden`;
  - seek to 5 -> `empty=0` next cycle, next `rden` returns 0x1005.
- WRAP=1: seek 31, `rden` x2 -> returns mem[31] then mem[0]; `empty`/`eof` stay 0.
- Host `wren` 0xAAAA and `hw_we` 0x5555 both at addr 7, same cycle -> mem[7]=0xAAAA. Repeat with `hw_waddr=8` -> mem[7]=0xAAAA and mem[8]=0x5555.
- `addr_update` (addr 12) coincident with `wren` at `ptr=4` -> mem[4] written, next write lands at 12. Open rising edge with no seek -> `ptr=0`.
